constant_addition_stage: RTL and testbench
==========================================

Name: constant_addition_stage

Overview:
- Registered, round-sequenced constant-addition stage of the Ascon permutation; sits directly upstream of substitution_layer.
- Tracks the current round number and XORs the matching round constant into the low byte of word x2.
- Presents the result on a one-deep registered valid/ready output that feeds substitution_layer.
- Supports p12 (start round 0), p8 (start round 4) and p6 (start round 6).

Parameters:
- NB_ROUNDS_MAX, 12, last round index + 1; round constant table size.
- ROUND_W, 4, width of the round counter.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse; loads the round counter from round_start_i.
- round_start_i  in  4  first round index: 0, 4 or 6.
- valid_i  in  1  state_i is valid.
- ready_o  out  1  stage can accept state_i this cycle.
- state_i  in  type_state  5x64 input state.
- valid_o  out  1  state_o holds a result.
- ready_i  in  1  downstream accepts state_o.
- state_o  out  type_state  registered output state.
- round_o  out  4  round index of the next input to be processed.
- last_round_o  out  1  high while state_o holds the round-11 result.

Behaviour:
- Reset (async assert, sync-safe deassert): FSM=IDLE, round counter=0, valid_o=0, state_o=all zero, last_round_o=0.
- FSM states: IDLE, ACTIVE.
- IDLE -> ACTIVE on start_i with round_start_i <= 11; counter <= round_start_i.
- start_i with round_start_i > 11: ignored; FSM unchanged.
- ACTIVE -> IDLE when the round-11 input is accepted.
- start_i while ACTIVE: restart. Counter reloads and ready_o is forced low that cycle, so no input is accepted. Already-registered output is unaffected.
- ready_o = (FSM==ACTIVE) && !start_i && (!valid_o || ready_i).
- Accept = valid_i && ready_o. On accept, in the same edge:
  - state_o <= state_i with state_o[2][7:0] = state_i[2][7:0] ^ C[r].
  - valid_o <= 1; last_round_o <= (r==11); counter <= r+1.
- Round constants: C[r] = 8'hF0 - r*8'h0F, i.e. F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B. Computed 8-bit; upper 56 bits of x2 and all other words pass unchanged.
- Latency: 1 cycle from accept to valid_o.
- Throughput: 1 state/cycle while ready_i is held high.
- Output hold: state_o, valid_o and last_round_o are stable while valid_o && !ready_i.
- valid_o clears on valid_o && ready_i with no new accept. If a new accept happens in the same cycle, the register reloads and valid_o stays high.
- round_o is the counter value; it is 0 in IDLE after reset. After ACTIVE->IDLE it holds 12 until the next start_i. The counter never wraps past 12.
- valid_i in IDLE: ignored, ready_o=0.
- Reset mid-operation: immediate return to the reset values; any in-flight output is discarded.

Optional Feature:
- Macro: CONST_ADD_ROUND_COUNT_EN.
- Defined: adds output port rounds_done_o [15:0].
  - Increments on every accept; wraps 16'hFFFF -> 0.
  - Cleared by reset_i only, not by start_i.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- ascon_pack holds: type_state; the round constant array (12 x 8-bit); constants ROUND_P12=0, ROUND_P8=4, ROUND_P6=6; the FSM state typedef.
- No sub-module: the constant lookup is an indexed package array; the FSM, counter and output register stay in this module.

Test Plan:
- IV vector:
  - Stimulus: reset, start_i with round_start_i=0; valid_i with x0=80400c0600000000, x1=8a55114d1cb6a9a2, x2=be263d4d7aecaaff, x3=4ed0ec0b98c529b7, x4=c8cddf37bcd0284a.
  - Response: next cycle valid_o=1, state_o[2]=be263d4d7aecaa0f, other words unchanged, round_o=1.
- Full p12 streaming:
  - Stimulus: ready_i=1, 12 back-to-back accepts of an all-zero state.
  - Response: state_o[2][7:0] sequence F0,E1,...,4B; last_round_o=1 only on the 12th; FSM returns to IDLE; ready_o=0 afterwards.
- p6 start:
  - Stimulus: round_start_i=6, all-zero input.
  - Response: first output x2 low byte=96; last_round_o on the 6th output; round_o=12 afterwards.
- Backpressure:
  - Stimulus: ready_i=0 after the first accept.
  - Response: ready_o=0, state_o/valid_o held for 5 cycles; on ready_i=1, handoff and next accept occur in the same cycle.
- Restart and invalid start:
  - Stimulus: start_i with round_start_i=4 during ACTIVE at round 7, with valid_i=1.
  - Response: no accept that cycle; next output constant=B4.
  - Stimulus: start_i with round_start_i=13 in IDLE.
  - Response: ignored.
- Async reset mid-stream:
  - Stimulus: reset_i pulsed between clock edges with valid_o=1.
  - Response: valid_o, state_o and round_o go to 0 immediately without a clock edge; rounds_done_o=0 when CONST_ADD_ROUND_COUNT_EN is defined.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared Ascon types for the permutation pipeline: 5x64 state, round
// constant table, permutation start rounds and the stage FSM encoding.
package ascon_pack;

  localparam int ASCON_NB_ROUNDS = 12;

  // First round index for each permutation variant
  localparam logic [3:0] ROUND_P12 = 4'd0;
  localparam logic [3:0] ROUND_P8  = 4'd4;
  localparam logic [3:0] ROUND_P6  = 4'd6;

  // Words x0..x4; x2 is index 2
  typedef logic [4:0][63:0] type_state;

  // C[r] = F0 - r*0F; entry [0] is round 0
  localparam logic [ASCON_NB_ROUNDS-1:0][7:0] ROUND_CONST = {
    8'h4B, 8'h5A, 8'h69, 8'h78, 8'h87, 8'h96,
    8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0
  };

  typedef enum logic {ST_IDLE, ST_ACTIVE} fsm_state_t;

endpackage

// File: rtl/constant_addition_stage_if.sv
// Handshake bundle between the round sequencer and the constant-addition
// stage (slave) and from the stage towards substitution_layer.
interface constant_addition_stage_if
  import ascon_pack::*;
#(
  parameter int ROUND_W = 4
);
  logic               start_i;
  logic [ROUND_W-1:0] round_start_i;
  logic               valid_i;
  logic               ready_o;
  type_state          state_i;
  logic               valid_o;
  logic               ready_i;
  type_state          state_o;
  logic [ROUND_W-1:0] round_o;
  logic               last_round_o;

  modport slave (
    input  start_i, round_start_i, valid_i, state_i, ready_i,
    output ready_o, valid_o, state_o, round_o, last_round_o
  );

  modport master (
    output start_i, round_start_i, valid_i, state_i, ready_i,
    input  ready_o, valid_o, state_o, round_o, last_round_o
  );
endinterface

// File: rtl/constant_addition_stage.sv
// Ascon constant-addition stage: tracks the round index, XORs C[r] into the
// low byte of x2 and hands the result out through a one-deep register.
// Optional macro CONST_ADD_ROUND_COUNT_EN adds a 16-bit accept counter port.
module constant_addition_stage
  import ascon_pack::*;
#(
  parameter int NB_ROUNDS_MAX = 12,
  parameter int ROUND_W       = 4
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  constant_addition_stage_if.slave      bus
`ifdef CONST_ADD_ROUND_COUNT_EN
  ,
  output logic [15:0]                   rounds_done_o
`endif
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NB_ROUNDS_MAX - 1);

  fsm_state_t         state_q, state_d;
  logic [ROUND_W-1:0] round_q;
  logic               start_ok;
  logic               accept;
  logic [7:0]         rc;
  type_state          added;

  // Out-of-range start requests are dropped entirely
  assign start_ok = bus.start_i && (bus.round_start_i <= LAST_ROUND);
  assign accept   = bus.valid_i && bus.ready_o;
  assign bus.round_o = round_q;

  // Counter only reaches NB_ROUNDS_MAX in IDLE, so the guard is a safety net
  assign rc = (round_q <= LAST_ROUND) ? ROUND_CONST[round_q] : 8'h00;

  // Constant lands in the low byte of x2; everything else passes through
  always_comb begin
    added         = bus.state_i;
    added[2][7:0] = bus.state_i[2][7:0] ^ rc;
  end

  // FSM state register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: a valid start (re)enters ACTIVE, round 11 accept exits
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (start_ok)                              state_d = ST_ACTIVE;
        else if (accept && round_q == LAST_ROUND)  state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM output: any start cycle blocks input so a restart never mixes rounds
  always_comb begin
    bus.ready_o = (state_q == ST_ACTIVE) && !bus.start_i &&
                  (!bus.valid_o || bus.ready_i);
  end

  // Round counter: reload on start, advance per accepted state
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)       round_q <= '0;
    else if (start_ok) round_q <= bus.round_start_i;
    else if (accept)   round_q <= round_q + ROUND_W'(1);
  end

  // Output register: load on accept, drop valid on handoff, hold otherwise
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      bus.valid_o      <= 1'b0;
      bus.state_o      <= '0;
      bus.last_round_o <= 1'b0;
    end else if (accept) begin
      bus.valid_o      <= 1'b1;
      bus.state_o      <= added;
      bus.last_round_o <= (round_q == LAST_ROUND);
    end else if (bus.valid_o && bus.ready_i) begin
      bus.valid_o      <= 1'b0;
      bus.last_round_o <= 1'b0;
    end
  end

`ifdef CONST_ADD_ROUND_COUNT_EN
  // Free-running accept count; only reset clears it
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)     rounds_done_o <= '0;
    else if (accept) rounds_done_o <= rounds_done_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_constant_addition_stage.sv
// Bench for constant_addition_stage: directed tables and sequences plus a
// randomized run, all checked against a round-level reference model.
module tb_constant_addition_stage;
  import ascon_pack::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  constant_addition_stage_if bus ();
`ifdef CONST_ADD_ROUND_COUNT_EN
  logic [15:0] rounds_done;
`endif

  constant_addition_stage dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
`ifdef CONST_ADD_ROUND_COUNT_EN
    ,
    .rounds_done_o (rounds_done)
`endif
  );

  typedef struct {
    logic [7:0] c;
    logic       last;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit        m_active;
  int        m_r;
  bit        m_vo;
  type_state m_st;
  bit        m_last;
  int        m_done;

  function automatic logic [7:0] ref_const(int r);
    return 8'(240 - r * 15);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_active = 0; m_r = 0; m_vo = 0; m_st = '0; m_last = 0; m_done = 0;
  endtask

  task automatic drive(bit s, logic [3:0] rs, bit v, bit rdy, type_state st);
    bus.start_i = s; bus.round_start_i = rs; bus.valid_i = v;
    bus.ready_i = rdy; bus.state_i = st;
  endtask

  // One clock: check ready, advance the model, clock, check outputs
  task automatic cyc();
    bit acc, rdy;
    #2;
    rdy = m_active && !bus.start_i && (!m_vo || bus.ready_i);
    chk("ready_o", 64'(bus.ready_o), 64'(rdy));
    acc = rdy && bus.valid_i;
    if (acc) begin
      m_st = bus.state_i;
      m_st[2][7:0] = m_st[2][7:0] ^ ref_const(m_r);
      m_vo = 1; m_last = (m_r == 11);
      if (m_r == 11) m_active = 0;
      m_r++;
      m_done = (m_done + 1) % 65536;
    end else if (m_vo && bus.ready_i) begin
      m_vo = 0; m_last = 0;
    end
    if (bus.start_i && bus.round_start_i <= 11) begin
      m_active = 1; m_r = int'(bus.round_start_i);
    end
    @(posedge clk); #1;
    chk("valid_o", 64'(bus.valid_o), 64'(m_vo));
    chk("round_o", 64'(bus.round_o), 64'(m_r));
    chk("last_round_o", 64'(bus.last_round_o), 64'(m_last));
    for (int w = 0; w < 5; w++) chk($sformatf("state_o[%0d]", w), bus.state_o[w], m_st[w]);
`ifdef CONST_ADD_ROUND_COUNT_EN
    chk("rounds_done_o", 64'(rounds_done), 64'(m_done));
`endif
  endtask

  task automatic start_seq(logic [3:0] rs);
    bus.start_i = 1; bus.round_start_i = rs; bus.valid_i = 0;
    cyc();
    bus.start_i = 0;
  endtask

  task automatic do_reset();
    rst = 1; #1; mdl_reset();
    @(posedge clk); #1; rst = 0;
  endtask

  type_state zero_st;
  type_state iv;
  type_state rs_st;
  logic [7:0] cb [12];
  vec_t tbl [12];

  initial begin
    zero_st = '0;
    iv[0] = 64'h80400c0600000000; iv[1] = 64'h8a55114d1cb6a9a2;
    iv[2] = 64'hbe263d4d7aecaaff; iv[3] = 64'h4ed0ec0b98c529b7;
    iv[4] = 64'hc8cddf37bcd0284a;
    cb = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
           8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    for (int i = 0; i < 12; i++) begin
      tbl[i].c = cb[i]; tbl[i].last = (i == 11);
    end

    // Reset values
    drive(0, 4'd0, 0, 1, zero_st);
    rst = 1; #1; mdl_reset();
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_round", 64'(bus.round_o), 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_last", 64'(bus.last_round_o), 64'd0);
    chk("rst_x2", bus.state_o[2], 64'd0);
    @(posedge clk); #1; rst = 0;

    // IV vector
    start_seq(ROUND_P12);
    drive(0, 4'd0, 1, 1, iv);
    cyc();
    chk("iv_x2", bus.state_o[2], 64'hbe263d4d7aecaa0f);
    chk("iv_x0", bus.state_o[0], 64'h80400c0600000000);
    chk("iv_x4", bus.state_o[4], 64'hc8cddf37bcd0284a);
    chk("iv_round", 64'(bus.round_o), 64'd1);
    bus.valid_i = 0;

    // Full p12 streaming (restart while ACTIVE)
    start_seq(ROUND_P12);
    drive(0, 4'd0, 1, 1, zero_st);
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("p12_const", 64'(bus.state_o[2][7:0]), 64'(tbl[i].c));
      chk("p12_last", 64'(bus.last_round_o), 64'(tbl[i].last));
    end
    cyc();
    chk("p12_idle_ready", 64'(bus.ready_o), 64'd0);
    chk("p12_round12", 64'(bus.round_o), 64'd12);
    bus.valid_i = 0;

    // p6 start
    start_seq(ROUND_P6);
    drive(0, 4'd0, 1, 1, zero_st);
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 0) chk("p6_first", 64'(bus.state_o[2][7:0]), 64'h96);
      chk("p6_last", 64'(bus.last_round_o), 64'(i == 5));
    end
    bus.valid_i = 0;
    cyc();
    chk("p6_round12", 64'(bus.round_o), 64'd12);

    // Backpressure: hold 5 cycles, then handoff + accept in one edge
    start_seq(ROUND_P12);
    drive(0, 4'd0, 1, 1, zero_st);
    cyc();
    bus.ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_hold_x2", 64'(bus.state_o[2][7:0]), 64'hF0);
      chk("bp_hold_valid", 64'(bus.valid_o), 64'd1);
    end
    bus.ready_i = 1;
    cyc();
    chk("bp_next_const", 64'(bus.state_o[2][7:0]), 64'hE1);
    chk("bp_next_valid", 64'(bus.valid_o), 64'd1);

    // Restart at round 7 with valid_i high
    for (int i = 0; i < 20 && m_r < 7; i++) cyc();
    chk("rs_at7", 64'(bus.round_o), 64'd7);
    bus.start_i = 1; bus.round_start_i = ROUND_P8;
    cyc();
    chk("rs_noaccept", 64'(bus.round_o), 64'd4);
    bus.start_i = 0;
    cyc();
    chk("rs_const", 64'(bus.state_o[2][7:0]), 64'hB4);

    // Invalid start in IDLE
    do_reset();
    drive(1, 4'd13, 0, 1, zero_st);
    cyc();
    drive(0, 4'd0, 1, 1, zero_st);
    cyc();
    chk("bad_start_ready", 64'(bus.ready_o), 64'd0);
    chk("bad_start_round", 64'(bus.round_o), 64'd0);
    chk("bad_start_valid", 64'(bus.valid_o), 64'd0);

    // Async reset between edges while valid_o is high
    start_seq(ROUND_P12);
    drive(0, 4'd0, 1, 0, iv);
    cyc();
    bus.valid_i = 0;
    #3; rst = 1; #1;
    chk("ar_valid", 64'(bus.valid_o), 64'd0);
    chk("ar_x2", bus.state_o[2], 64'd0);
    chk("ar_x0", bus.state_o[0], 64'd0);
    chk("ar_round", 64'(bus.round_o), 64'd0);
`ifdef CONST_ADD_ROUND_COUNT_EN
    chk("ar_done", 64'(rounds_done), 64'd0);
`endif
    mdl_reset();
    @(posedge clk); #1; rst = 0;

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      for (int w = 0; w < 5; w++) rs_st[w] = {$urandom, $urandom};
      bus.start_i = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: bus.round_start_i = ROUND_P12;
        1: bus.round_start_i = ROUND_P8;
        2: bus.round_start_i = ROUND_P6;
        default: bus.round_start_i = 4'($urandom_range(0, 15));
      endcase
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.ready_i = ($urandom_range(0, 2) != 0);
      bus.state_i = rs_st;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
